// File: rtl/matrix_load_sequencer.sv
// rtl/matrix_load_sequencer.sv - sequences one matrix/vector operand load from the host byte stream into the bank DEMUX
module matrix_load_sequencer #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [7:0]        size_x,
    input  logic [7:0]        size_y,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [7:0]        write_mat_type,
    output logic              o_wr_en,
    output logic [2:0]        o_wr_row,
    output logic [2:0]        o_wr_col,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);
    localparam logic [7:0] MIN_DIM_B = 8'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;

    // Dimensions captured at i_start; they drive CHECK and the column wrap point.
    logic [7:0] size_x_q;
    logic [7:0] size_y_q;

    // Load progress: element count, row-major indices and the column wrap value.
    logic [4:0] elem_total_q;
    logic [4:0] elem_cnt_q;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [2:0] last_col_q;

    // Registered outputs.
    logic              ready_q;
    logic [7:0]        mat_type_q;
    logic              wr_en_q;
    logic [2:0]        wr_row_q;
    logic [2:0]        wr_col_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    // Decode of the latched dimensions, used only while in CHECK.
    logic       is_vector;
    logic       dims_legal;
    logic [7:0] mat_type_d;
    logic [2:0] dim3;
    logic [4:0] dim5;
    logic [4:0] square_cnt;
    logic [4:0] elem_total_d;
    logic [2:0] last_col_d;

    // Handshake and index advance, used only while in LOAD.
    logic       xfer;
    logic       col_wrap;
    logic       last_elem;

    // Dimension check and the matrix type / element count it implies.
    always_comb begin
        is_vector    = (size_y_q == 8'd0);
        dims_legal   = (size_x_q >= MIN_DIM_B) && (size_x_q <= MAX_DIM_B) &&
                       (is_vector || (size_y_q == size_x_q));
        mat_type_d   = is_vector ? (size_x_q + 8'd3) : (size_x_q - 8'd1);
        dim3         = size_x_q[2:0];
        dim5         = {2'b00, dim3};
        square_cnt   = dim5 * dim5;
        elem_total_d = is_vector ? dim5 : square_cnt;
        last_col_d   = dim3 - 3'd1;
    end

    // Transfer qualification and row-major wrap points.
    always_comb begin
        xfer      = ready_q && i_data_valid;
        col_wrap  = (col_q == last_col_q);
        last_elem = (elem_cnt_q == (elem_total_q - 5'd1));
    end

    // Load sequencer: latch, check, stream elements with a one-cycle strobe, then pulse done.
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            size_x_q     <= 8'd0;
            size_y_q     <= 8'd0;
            elem_total_q <= 5'd0;
            elem_cnt_q   <= 5'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            last_col_q   <= 3'd0;
            ready_q      <= 1'b0;
            mat_type_q   <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_row_q     <= 3'd0;
            wr_col_q     <= 3'd0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        size_x_q <= size_x;
                        size_y_q <= size_y;
                        error_q  <= 1'b0;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dims_legal) begin
                        mat_type_q   <= mat_type_d;
                        elem_total_q <= elem_total_d;
                        last_col_q   <= last_col_d;
                        elem_cnt_q   <= 5'd0;
                        row_q        <= 3'd0;
                        col_q        <= 3'd0;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_LOAD;
                    end else begin
                        // Bad dimensions leave the previous DEMUX select in place.
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        wr_en_q    <= 1'b1;
                        wr_data_q  <= i_data;
                        wr_row_q   <= row_q;
                        wr_col_q   <= col_q;
                        elem_cnt_q <= elem_cnt_q + 5'd1;
                        if (col_wrap) begin
                            col_q <= 3'd0;
                            row_q <= row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                        // Ready falls together with the final strobe so no extra byte is taken.
                        if (last_elem) begin
                            ready_q <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data_ready   = ready_q;
    assign write_mat_type = mat_type_q;
    assign o_wr_en        = wr_en_q;
    assign o_wr_row       = wr_row_q;
    assign o_wr_col       = wr_col_q;
    assign o_wr_data      = wr_data_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// tb/tb_matrix_load_sequencer.sv - directed scoreboard bench for matrix_load_sequencer
module tb_matrix_load_sequencer;

    logic       i_clk;
    logic       reset;
    logic       i_start;
    logic [7:0] size_x;
    logic [7:0] size_y;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_data_ready;
    logic [7:0] write_mat_type;
    logic       o_wr_en;
    logic [2:0] o_wr_row;
    logic [2:0] o_wr_col;
    logic [7:0] o_wr_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    matrix_load_sequencer #(.DATA_W(8), .MAX_DIM(5)) dut (
        .i_clk          (i_clk),
        .reset          (reset),
        .i_start        (i_start),
        .size_x         (size_x),
        .size_y         (size_y),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .o_data_ready   (o_data_ready),
        .write_mat_type (write_mat_type),
        .o_wr_en        (o_wr_en),
        .o_wr_row       (o_wr_row),
        .o_wr_col       (o_wr_col),
        .o_wr_data      (o_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   strobes  = 0;
    logic xfer_pend;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: the bench knows whether it handed over a byte before each edge.
    always @(posedge i_clk) begin
        logic exp_wr;
        exp_t e;
        exp_wr = xfer_pend;
        #1;
        check("wr_en", {31'd0, o_wr_en}, {31'd0, exp_wr});
        if (o_wr_en === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL strobe_without_expected observed=%0h expected=none", o_wr_data);
            end else begin
                e = q.pop_front();
                check("wr_row", {29'd0, o_wr_row}, {29'd0, e.row});
                check("wr_col", {29'd0, o_wr_col}, {29'd0, e.col});
                check("wr_data", {24'd0, o_wr_data}, {24'd0, e.data});
                strobes++;
            end
        end
    end

    task automatic run_load(input int sx, input int sy, input logic [7:0] base,
                            input logic [31:0] vpat, input int vlen, input int start_at);
        int   n;
        int   sent;
        int   cyc;
        int   mt;
        logic v;
        exp_t e;
        n       = (sy == 0) ? sx : sx * sx;
        mt      = (sy == 0) ? sx + 3 : sx - 1;
        strobes = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        size_x  = 8'(sx);
        size_y  = 8'(sy);
        @(negedge i_clk);
        i_start = 1'b0;
        check("ready_in_check", {31'd0, o_data_ready}, 32'd0);
        @(negedge i_clk);
        check("ready_in_load", {31'd0, o_data_ready}, 32'd1);
        check("busy_in_load", {31'd0, o_busy}, 32'd1);
        check("error_cleared", {31'd0, o_error}, 32'd0);
        check("mat_type", {24'd0, write_mat_type}, 32'(mt));
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 200) begin
            v = (cyc < vlen) ? vpat[cyc] : 1'b1;
            i_data_valid = v;
            i_start      = (cyc == start_at);
            if (cyc == start_at) begin
                size_x = 8'd2;
                size_y = 8'd0;
            end
            if (v) begin
                i_data = base + 8'(sent);
                e.row  = (sy == 0) ? 3'd0 : 3'(sent / sx);
                e.col  = 3'(sent % sx);
                e.data = i_data;
                q.push_back(e);
                sent++;
            end
            xfer_pend = v;
            cyc++;
            @(negedge i_clk);
        end
        i_data_valid = 1'b0;
        i_start      = 1'b0;
        xfer_pend    = 1'b0;
        check("all_sent", 32'(sent), 32'(n));
        check("ready_after_last", {31'd0, o_data_ready}, 32'd0);
        check("busy_last_strobe", {31'd0, o_busy}, 32'd1);
        check("done_early", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        check("done_pulse", {31'd0, o_done}, 32'd1);
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        check("done_cleared", {31'd0, o_done}, 32'd0);
        check("strobe_count", 32'(strobes), 32'(n));
        check("sb_empty", 32'(q.size()), 32'd0);
        check("mat_type_hold", {24'd0, write_mat_type}, 32'(mt));
    endtask

    task automatic run_illegal(input int sx, input int sy, input int prev_mt);
        @(negedge i_clk);
        i_start = 1'b1;
        size_x  = 8'(sx);
        size_y  = 8'(sy);
        @(negedge i_clk);
        i_start = 1'b0;
        check("ill_error_cleared", {31'd0, o_error}, 32'd0);
        @(negedge i_clk);
        check("ill_error_set", {31'd0, o_error}, 32'd1);
        check("ill_ready", {31'd0, o_data_ready}, 32'd0);
        check("ill_busy", {31'd0, o_busy}, 32'd0);
        check("ill_mat_type", {24'd0, write_mat_type}, 32'(prev_mt));
        repeat (2) @(negedge i_clk);
        check("ill_ready_idle", {31'd0, o_data_ready}, 32'd0);
        check("ill_error_sticky", {31'd0, o_error}, 32'd1);
        check("ill_no_done", {31'd0, o_done}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, o_data_ready}, 32'd0);
        check({tag, "_mat_type"}, {24'd0, write_mat_type}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
        check({tag, "_wr_row"}, {29'd0, o_wr_row}, 32'd0);
        check({tag, "_wr_col"}, {29'd0, o_wr_col}, 32'd0);
        check({tag, "_wr_data"}, {24'd0, o_wr_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
        check({tag, "_error"}, {31'd0, o_error}, 32'd0);
    endtask

    initial begin
        exp_t e;
        reset        = 1'b0;
        i_start      = 1'b0;
        size_x       = 8'd0;
        size_y       = 8'd0;
        i_data       = 8'd0;
        i_data_valid = 1'b0;
        xfer_pend    = 1'b0;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        reset = 1'b1;

        // 3x3 square, continuous valid.
        run_load(3, 3, 8'h10, 32'd0, 0, -1);
        // 5-element vector.
        run_load(5, 0, 8'h30, 32'd0, 0, -1);
        // Illegal dimensions keep the last select (8) and raise error.
        run_illegal(6, 6, 8);
        run_illegal(1, 0, 8);
        run_illegal(3, 4, 8);
        // 2x2 with valid pattern 1,0,0,1,1,0,1; this legal start also clears error.
        run_load(2, 2, 8'h50, 32'h59, 7, -1);

        // Reset after 3 of 4 elements of a 2x2 load.
        @(negedge i_clk);
        i_start = 1'b1;
        size_x  = 8'd2;
        size_y  = 8'd2;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            i_data_valid = 1'b1;
            i_data       = 8'hA0 + 8'(i);
            e.row        = 3'(i / 2);
            e.col        = 3'(i % 2);
            e.data       = i_data;
            q.push_back(e);
            xfer_pend    = 1'b1;
            @(negedge i_clk);
        end
        i_data_valid = 1'b0;
        xfer_pend    = 1'b0;
        reset        = 1'b0;
        @(negedge i_clk);
        check_all_zero("midreset");
        reset = 1'b1;
        @(negedge i_clk);
        check("midreset_no_done", {31'd0, o_done}, 32'd0);
        check("midreset_sb_empty", 32'(q.size()), 32'd0);
        run_load(2, 2, 8'h70, 32'd0, 0, -1);

        // i_start pulsed (with other sizes) mid-way through a 4x4 load is ignored.
        run_load(4, 4, 8'h80, 32'd0, 0, 5);

        repeat (2) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
